// File: rtl/snn_layer_mac.sv
// Sequencer and MAC engine for one fully connected spiking layer: scans spike and weight RAMs,
// accumulates weights of spiking inputs and writes a shifted, clamped activation per neuron.
module snn_layer_mac #(
    parameter int unsigned IN_COUNT       = 784,
    parameter int unsigned OUT_COUNT      = 32,
    parameter int unsigned IN_ADDR_WIDTH  = 10,
    parameter int unsigned W_ADDR_WIDTH   = 15,
    parameter int unsigned OUT_ADDR_WIDTH = 5,
    parameter int unsigned W_WIDTH        = 8,
    parameter int unsigned ACC_WIDTH      = 18,
    parameter int unsigned SHIFT          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [IN_ADDR_WIDTH-1:0]  in_addr,
    input  logic                      in_q,
    output logic [W_ADDR_WIDTH-1:0]   w_addr,
    input  logic [W_WIDTH-1:0]        w_q,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr,
    output logic [7:0]                out_data,
    output logic                      out_we,
    output logic                      busy,
    output logic                      done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [IN_ADDR_WIDTH-1:0]  IN_LAST  = IN_ADDR_WIDTH'(IN_COUNT - 1);
    localparam logic [OUT_ADDR_WIDTH-1:0] OUT_LAST = OUT_ADDR_WIDTH'(OUT_COUNT - 1);

    localparam logic signed [ACC_WIDTH-1:0] ACT_ZERO = '0;
    localparam logic signed [ACC_WIDTH-1:0] ACT_MAX  = ACC_WIDTH'(255);

    logic [2:0]                    state_q, state_d;
    logic [IN_ADDR_WIDTH-1:0]      i_q, i_d;
    logic [W_ADDR_WIDTH-1:0]       w_addr_q, w_addr_d;
    logic [OUT_ADDR_WIDTH-1:0]     n_q, n_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          vld_q, vld_d;
    logic [7:0]                    out_data_q, out_data_d;
    logic                          out_we_q, out_we_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic signed [ACC_WIDTH-1:0]   w_ext;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0]   acc_shr;

    function automatic logic [7:0] clamp8(input logic signed [ACC_WIDTH-1:0] v);
        if (v <= ACT_ZERO) begin
            return 8'd0;
        end else if (v >= ACT_MAX) begin
            return 8'hff;
        end else begin
            return v[7:0];
        end
    endfunction

    assign w_ext   = {{(ACC_WIDTH - W_WIDTH){w_q[W_WIDTH-1]}}, w_q};
    // Data returned this cycle belongs to the address issued last cycle, flagged by vld_q.
    assign acc_sum = (vld_q && in_q) ? acc_q + w_ext : acc_q;
    assign acc_shr = acc_sum >>> SHIFT;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        w_addr_d   = w_addr_q;
        n_d        = n_q;
        acc_d      = acc_sum;
        vld_d      = 1'b0;
        out_data_d = 8'd0;
        out_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_READ;
                    i_d      = '0;
                    n_d      = '0;
                    w_addr_d = '0;
                    acc_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_READ: begin
                vld_d = 1'b1;
                if (i_q == IN_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d      = i_q + 1'b1;
                    w_addr_d = w_addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // acc_sum already includes the final returned pair.
                state_d    = ST_WRITE;
                out_we_d   = 1'b1;
                out_data_d = clamp8(acc_shr);
            end
            ST_WRITE: begin
                if (n_q == OUT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_READ;
                    n_d      = n_q + 1'b1;
                    i_d      = '0;
                    w_addr_d = w_addr_q + 1'b1;
                    acc_d    = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            w_addr_q   <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            vld_q      <= 1'b0;
            out_data_q <= 8'd0;
            out_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            w_addr_q   <= w_addr_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            vld_q      <= vld_d;
            out_data_q <= out_data_d;
            out_we_q   <= out_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_addr  = i_q;
    assign w_addr   = w_addr_q;
    assign out_addr = n_q;
    assign out_data = out_data_q;
    assign out_we   = out_we_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
